waterfall_write_arbiter: RTL

- Shares the single write port of the waterfall column storage between the low-band and high-band processed sample streams.
- Buffers each stream in a small FIFO and grants the write port round-robin.
- Generates per-channel line addresses (0..LINES-1) with start-of-frame realignment and wrap.
- Flags dropped samples and signals completed frames to the display side.
- Sits between the two filter/FFT outputs and the column framebuffers, in the data clock domain.

---
 rtl/waterfall_write_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/waterfall_write_arbiter.sv
// waterfall_write_arbiter: FIFO-buffered round-robin arbiter sharing the column write port between low and high bands
module waterfall_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int LINES      = 480,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_data,
    input  logic                  reset_n,
    input  logic                  low_sink_valid,
    input  logic [DATA_WIDTH-1:0] low_sink_data,
    input  logic                  low_sink_sop,
    input  logic                  high_sink_valid,
    input  logic [DATA_WIDTH-1:0] high_sink_data,
    input  logic                  high_sink_sop,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic                  wr_sel,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  low_frame_done,
    output logic                  high_frame_done,
    output logic                  low_overflow,
    output logic                  high_overflow,
    input  logic                  clear_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LINES - 1);

    logic [DATA_WIDTH:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH:0] mem_h [FIFO_DEPTH];
    logic [PW:0] wp_l, rp_l, wp_h, rp_h;
    logic [ADDR_WIDTH-1:0] cnt_l, cnt_h, addr_sel, addr_next;
    logic [DATA_WIDTH:0] head;
    logic last_high, empty_l, empty_h, full_l, full_h, xfer, reload;
    logic pop_l, pop_h, push_l, push_h, drop_l, drop_h;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_l   = wp_l == rp_l;
        empty_h   = wp_h == rp_h;
        full_l    = (wp_l - rp_l) == FULL_CNT;
        full_h    = (wp_h - rp_h) == FULL_CNT;
        xfer      = wr_en && wr_ready;
        reload    = !wr_en || wr_ready;
        pop_l     = reload && !empty_l && (empty_h || last_high);
        pop_h     = reload && !empty_h && !pop_l;
        push_l    = low_sink_valid && (!full_l || pop_l);
        push_h    = high_sink_valid && (!full_h || pop_h);
        drop_l    = low_sink_valid && !push_l;
        drop_h    = high_sink_valid && !push_h;
        head      = pop_h ? mem_h[rp_h[PW-1:0]] : mem_l[rp_l[PW-1:0]];
        addr_sel  = head[DATA_WIDTH] ? '0 : (pop_h ? cnt_h : cnt_l);
        addr_next = addr_sel == LAST ? '0 : addr_sel + 1'b1;
    end

    always_ff @(posedge clk_data or negedge reset_n) begin
        if (!reset_n) begin
            wp_l            <= '0;
            rp_l            <= '0;
            wp_h            <= '0;
            rp_h            <= '0;
            cnt_l           <= '0;
            cnt_h           <= '0;
            last_high       <= 1'b1;
            wr_en           <= 1'b0;
            wr_sel          <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            low_frame_done  <= 1'b0;
            high_frame_done <= 1'b0;
            low_overflow    <= 1'b0;
            high_overflow   <= 1'b0;
        end else begin
            if (push_l) wp_l <= wp_l + 1'b1;
            if (push_h) wp_h <= wp_h + 1'b1;
            if (pop_l) rp_l <= rp_l + 1'b1;
            if (pop_h) rp_h <= rp_h + 1'b1;
            if (pop_l) cnt_l <= addr_next;
            if (pop_h) cnt_h <= addr_next;
            if (reload) wr_en <= pop_l || pop_h;
            if (pop_l || pop_h) begin
                last_high <= pop_h;
                wr_sel    <= pop_h;
                wr_addr   <= addr_sel;
                wr_data   <= head[DATA_WIDTH-1:0];
            end
            low_frame_done  <= xfer && !wr_sel && wr_addr == LAST;
            high_frame_done <= xfer && wr_sel && wr_addr == LAST;
            low_overflow    <= drop_l || (low_overflow && !clear_overflow);
            high_overflow   <= drop_h || (high_overflow && !clear_overflow);
        end
    end

    always_ff @(posedge clk_data) begin
        if (push_l) mem_l[wp_l[PW-1:0]] <= {low_sink_sop, low_sink_data};
        if (push_h) mem_h[wp_h[PW-1:0]] <= {high_sink_sop, high_sink_data};
    end
endmodule
